// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: two's-complement (or unsigned) product to
// sign + magnitude BCD digits, one bit per clock, for the decimal 7-segment display.
module product_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            msd_idx
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] work_bcd;
  logic [4*DIGITS-1:0] work_adj;
  logic [CW-1:0]       cnt;
  logic                sign_r;
  logic                in_sign;
  logic [WIDTH-1:0]    in_mag;
  logic [2:0]          msd_c;

  assign busy    = (state != IDLE);
  assign in_sign = SIGNED & in_data[WIDTH-1];
  // Negation is done in WIDTH-bit unsigned arithmetic, so the most negative input
  // maps onto its own bit pattern, which reads as the correct magnitude.
  assign in_mag  = in_sign ? (~in_data + 1'b1) : in_data;

  always_comb begin
    work_adj = work_bcd;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_bcd[4*k +: 4] >= 4'd5)
        work_adj[4*k +: 4] = work_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    msd_c = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_bcd[4*k +: 4] != 4'd0)
        msd_c = 3'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CONV;
      CONV:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag      <= '0;
      work_bcd <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag      <= in_mag;
            work_bcd <= '0;
            cnt      <= CW'(WIDTH);
            sign_r   <= in_sign;
          end
        end
        CONV: begin
          work_bcd <= {work_adj[4*DIGITS-2:0], mag[WIDTH-1]};
          mag      <= {mag[WIDTH-2:0], 1'b0};
          cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      neg       <= 1'b0;
      bcd       <= '0;
      msd_idx   <= '0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) begin
        bcd     <= work_bcd;
        neg     <= sign_r;
        msd_idx <= msd_c;
      end
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed and random checks of product_bcd_converter, signed and unsigned instances.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid_u = 1'b0;
  logic [15:0] in_data = '0, in_data_u = '0;
  logic        busy, out_valid, neg;
  logic        busy_u, out_valid_u, neg_u;
  logic [19:0] bcd, bcd_u;
  logic [2:0]  msd_idx, msd_idx_u;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .out_valid(out_valid), .neg(neg), .bcd(bcd), .msd_idx(msd_idx)
  );

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_data(in_data_u),
    .busy(busy_u), .out_valid(out_valid_u), .neg(neg_u), .bcd(bcd_u), .msd_idx(msd_idx_u)
  );

  typedef struct {
    logic [15:0] data;
    logic        neg;
    logic [19:0] bcd;
    logic [2:0]  msd;
  } vec_t;

  typedef struct {
    logic        neg;
    logic [19:0] bcd;
    logic [2:0]  msd;
  } res_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] d, input bit is_signed);
    res_t r;
    int v;
    int m;
    v = is_signed ? int'($signed(d)) : int'($unsigned(d));
    r.neg = (v < 0);
    m = (v < 0) ? -v : v;
    r.bcd = '0;
    r.msd = '0;
    for (int i = 0; i < 5; i++) begin
      r.bcd[4*i +: 4] = 4'(m % 10);
      if ((m % 10) != 0) r.msd = 3'(i);
      m = m / 10;
    end
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the cycle following out_valid.
  task automatic run_conv(input bit u, input logic [15:0] d, input string nm,
                          input logic e_neg, input logic [19:0] e_bcd, input logic [2:0] e_msd);
    int  k;
    bit  seen;
    if (u) begin in_valid_u = 1'b1; in_data_u = d; end
    else   begin in_valid   = 1'b1; in_data   = d; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_u = 1'b0;
    k = 0; seen = 0;
    while (k < 40 && !seen) begin
      @(posedge clk); #1;
      k++;
      seen = u ? out_valid_u : out_valid;
    end
    chk({nm, " latency"}, k, 17);
    chk({nm, " neg"}, u ? neg_u : neg, e_neg);
    chk({nm, " bcd"}, u ? bcd_u : bcd, e_bcd);
    chk({nm, " msd"}, u ? msd_idx_u : msd_idx, e_msd);
    @(posedge clk); #1;
    chk({nm, " pulse_end"}, u ? out_valid_u : out_valid, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    int   pulses;
    bit   prev_busy;
    logic [19:0] got_bcd;
    logic [15:0] rd;
    res_t r;

    vecs.push_back('{16'd15,    1'b0, 20'h00015, 3'd1});
    vecs.push_back('{16'hFFF1,  1'b1, 20'h00015, 3'd1});
    vecs.push_back('{16'd0,     1'b0, 20'h00000, 3'd0});
    vecs.push_back('{16'h8000,  1'b1, 20'h32768, 3'd4});
    vecs.push_back('{16'h7FFF,  1'b0, 20'h32767, 3'd4});
    vecs.push_back('{16'h8001,  1'b1, 20'h32767, 3'd4});
    vecs.push_back('{16'hFFFF,  1'b1, 20'h00001, 3'd0});
    vecs.push_back('{16'd1,     1'b0, 20'h00001, 3'd0});
    vecs.push_back('{16'd10,    1'b0, 20'h00010, 3'd1});
    vecs.push_back('{16'd100,   1'b0, 20'h00100, 3'd2});
    vecs.push_back('{16'd9999,  1'b0, 20'h09999, 3'd3});
    vecs.push_back('{16'd10000, 1'b0, 20'h10000, 3'd4});
    vecs.push_back('{16'd1234,  1'b0, 20'h01234, 3'd3});

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst neg", neg, 1'b0);
    chk("rst bcd", bcd, 20'h0);
    chk("rst msd", msd_idx, 3'd0);
    chk("rst bcd_u", bcd_u, 20'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_conv(1'b0, vecs[i].data, $sformatf("vec%0d", i), vecs[i].neg, vecs[i].bcd, vecs[i].msd);

    // Outputs hold while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold bcd", bcd, 20'h01234);
    chk("hold msd", msd_idx, 3'd3);

    // in_valid while busy is ignored
    in_valid = 1'b1; in_data = 16'd1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 16'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses = 0; prev_busy = busy; got_bcd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        pulses++;
        got_bcd = bcd;
        chk("busy_ign latency", k, 12);
        chk("busy_ign busy_before", prev_busy, 1'b1);
        chk("busy_ign busy_after", busy, 1'b0);
      end
      prev_busy = busy;
    end
    chk("busy_ign pulses", pulses, 1);
    chk("busy_ign bcd", got_bcd, 20'h01234);

    // Held in_valid starts one conversion
    in_valid = 1'b1; in_data = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("held pulses", pulses, 1);
    chk("held bcd", bcd, 20'h00007);

    // Reset mid-conversion
    in_valid = 1'b1; in_data = 16'd500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst bcd", bcd, 20'h0);
    chk("midrst neg", neg, 1'b0);
    chk("midrst msd", msd_idx, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) pulses++;
    end
    chk("midrst no_activity", pulses, 0);
    run_conv(1'b0, 16'd500, "after_rst", 1'b0, 20'h00500, 3'd2);

    // Unsigned instance
    run_conv(1'b1, 16'hFFFF, "uns_ffff", 1'b0, 20'h65535, 3'd4);
    run_conv(1'b1, 16'h8000, "uns_8000", 1'b0, 20'h32768, 3'd4);

    // Random against integer math
    for (int i = 0; i < 12; i++) begin
      rd = 16'($urandom);
      r = model(rd, 1'b1);
      run_conv(1'b0, rd, $sformatf("rnd_s%0d_%h", i, rd), r.neg, r.bcd, r.msd);
      rd = 16'($urandom);
      r = model(rd, 1'b0);
      run_conv(1'b1, rd, $sformatf("rnd_u%0d_%h", i, rd), r.neg, r.bcd, r.msd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
